// File: rtl/codificador_letreiro.sv
// codificador_letreiro: scrolls the 8-symbol message "gabriel " across four displays, automatically or by manual step
module codificador_letreiro #(
  parameter int DIV_MAX = 49_999_999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       direcao,
  input  logic       passo,
  output logic [2:0] codigo3,
  output logic [2:0] codigo2,
  output logic [2:0] codigo1,
  output logic [2:0] codigo0,
  output logic [2:0] posicao,
  output logic       avanco,
  output logic       ciclo_completo
);
  localparam logic [25:0] TC = 26'(DIV_MAX);
  localparam logic [2:0] MSG [8] = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [25:0] cnt_q, cnt_d;
  logic [2:0]  pos_q, pos_d;
  logic        passo_q, passo_d, arm_q, avanco_q, avanco_d, ciclo_q, ciclo_d;
  logic        tc, step;
  // arm_q blocks the first post-reset cycle so a passo held through reset cannot step
  always_comb begin
    tc       = enable && cnt_q == TC;
    step     = !enable && passo && !passo_q && arm_q;
    avanco_d = tc || step;
    cnt_d    = enable ? (tc ? '0 : cnt_q + 26'd1) : cnt_q;
    pos_d    = avanco_d ? (direcao ? pos_q - 3'd1 : pos_q + 3'd1) : pos_q;
    passo_d  = passo;
    ciclo_d  = avanco_d && (direcao ? pos_q == 3'd0 : pos_q == 3'd7);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      pos_q    <= '0;
      passo_q  <= 1'b0;
      arm_q    <= 1'b0;
      avanco_q <= 1'b0;
      ciclo_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      passo_q  <= passo_d;
      arm_q    <= 1'b1;
      avanco_q <= avanco_d;
      ciclo_q  <= ciclo_d;
    end
  end
  assign codigo3        = MSG[pos_q];
  assign codigo2        = MSG[pos_q + 3'd1];
  assign codigo1        = MSG[pos_q + 3'd2];
  assign codigo0        = MSG[pos_q + 3'd3];
  assign posicao        = pos_q;
  assign avanco         = avanco_q;
  assign ciclo_completo = ciclo_q;
endmodule

// File: tb/tb_codificador_letreiro.sv
// tb_codificador_letreiro: scoreboard bench against a string-based model of the scrolling message
module tb_codificador_letreiro;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, direcao = 1'b0, passo = 1'b0;
  logic [2:0] codigo3, codigo2, codigo1, codigo0, posicao;
  logic avanco, ciclo_completo;
  int n_cmp = 0, n_bad = 0;
  logic [16:0] sb [$];
  bit done = 0;
  string msg = "gabriel ";
  int m_pos = 0, m_cnt = 0;
  bit m_prev = 0, m_armed = 0;

  codificador_letreiro #(.DIV_MAX(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .direcao(direcao), .passo(passo),
    .codigo3(codigo3), .codigo2(codigo2), .codigo1(codigo1), .codigo0(codigo0),
    .posicao(posicao), .avanco(avanco), .ciclo_completo(ciclo_completo)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] code(input byte c);
    case (c)
      "b": return 3'd0;
      "r": return 3'd1;
      "i": return 3'd2;
      "e": return 3'd3;
      "l": return 3'd4;
      " ": return 3'd5;
      "g": return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [11:0] window(input int p);
    return {code(msg[p % 8]), code(msg[(p + 1) % 8]), code(msg[(p + 2) % 8]), code(msg[(p + 3) % 8])};
  endfunction

  task automatic tick(input bit r, input bit e, input bit d, input bit p);
    bit adv, cc;
    @(negedge clk);
    reset = r; enable = e; direcao = d; passo = p;
    adv = 0; cc = 0;
    if (r) begin
      m_pos = 0; m_cnt = 0; m_prev = 0; m_armed = 0;
    end else begin
      if (e) begin
        adv = (m_cnt == 3);
        m_cnt = adv ? 0 : m_cnt + 1;
      end else
        adv = p && !m_prev && m_armed;
      m_prev = p;
      m_armed = 1;
      if (adv) begin
        cc = d ? (m_pos == 0) : (m_pos == 7);
        m_pos = d ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
      end
    end
    sb.push_back({3'(m_pos), adv, cc, window(m_pos)});
  endtask

  initial begin
    logic [16:0] exp, act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        act = {posicao, avanco, ciclo_completo, codigo3, codigo2, codigo1, codigo0};
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL outputs@%0t: got pos=%0d av=%b cc=%b codes=%o, expected pos=%0d av=%b cc=%b codes=%o",
                   $time, act[16:14], act[13], act[12], act[11:0], exp[16:14], exp[13], exp[12], exp[11:0]);
        end
      end
    end
  end

  initial begin
    bit e = 0;
    repeat (2) tick(1, 0, 0, 0);
    repeat (16) tick(0, 1, 0, 0);
    repeat (24) tick(0, 1, 0, 0);
    repeat (2) tick(1, 0, 0, 0);
    repeat (8) tick(0, 1, 1, 0);
    repeat (2) begin
      repeat (5) tick(0, 0, 0, 1);
      repeat (2) tick(0, 0, 0, 0);
    end
    repeat (5) tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) tick(0, 1, 0, i[0]);
    while (m_pos != 5) tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 1);
    tick(1, 1, 0, 1);
    repeat (4) tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 1);
    repeat (2) tick(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) e = ~e;
      tick($urandom_range(0, 99) == 0, e, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    done = 1;
  end

  initial begin
    wait (done);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/codificador_letreiro.md
CODIFICADOR_LETREIRO -- requirements
Module: codificador_letreiro

Interface
REQ-001 Parameter DIV_MAX, default 49_999_999; prescaler terminal count; one advance every DIV_MAX+1 enabled cycles; legal range 1..2^26-1.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  1 = automatic scrolling; 0 = paused, manual stepping allowed.
REQ-005 direcao  input  1  0 = forward (position +1); 1 = reverse (position -1).
REQ-006 passo  input  1  manual step request; level input, edge-detected internally.
REQ-007 codigo3  output  3  character code for the leftmost display.
REQ-008 codigo2  output  3  character code for display 2.
REQ-009 codigo1  output  3  character code for display 1.
REQ-010 codigo0  output  3  character code for the rightmost display.
REQ-011 posicao  output  3  current message pointer, 0..7.
REQ-012 avanco  output  1  one-cycle pulse on each position change.
REQ-013 ciclo_completo  output  1  one-cycle pulse when the pointer wraps.

Function
REQ-014 Character code map: b=000, r=001, i=010, e=011, l=100, space=101, g=110, a=111; the 7-segment display decoder consumes these codes unchanged.
REQ-015 Fixed 8-symbol message "gabriel ", index 0..7 = 110, 111, 000, 001, 010, 011, 100, 101.
REQ-016 Window: codigo3=msg[p], codigo2=msg[(p+1) mod 8], codigo1=msg[(p+2) mod 8], codigo0=msg[(p+3) mod 8], with p=posicao.
REQ-017 Codes are a combinational function of the registered posicao; codes change in the same cycle that posicao changes.
REQ-018 Prescaler: 26-bit counter; when enable=1, increments each cycle; at DIV_MAX, wraps to 0 on the next edge, and that edge generates an advance.
REQ-019 When enable=0, the prescaler holds its value: frozen, not cleared.
REQ-020 Manual step: passo is registered each cycle; a step occurs on the edge where passo=1 and the previous sample was 0; a held-high passo yields exactly one step.
REQ-021 Manual steps act only when enable=0; when enable=1, passo edges are ignored, but the edge-detect register still updates.
REQ-022 Advance arithmetic: forward 7->0 wraps; reverse 0->7 wraps; all arithmetic is modulo 8.
REQ-023 direcao is sampled at the advancing edge; a change of direcao between advances takes effect on the next advance, with no extra step.
REQ-024 avanco=1 for exactly the cycle following each advancing edge (registered pulse); otherwise 0.
REQ-025 ciclo_completo=1 in that same cycle only if the advance was a forward 7->0 or a reverse 0->7; otherwise 0.
REQ-026 An enable transition 1->0 coincident with a prescaler terminal count still performs that advance; enable 0->1 resumes from the frozen count.
REQ-027 At most one advance occurs per clock cycle.

Reset
REQ-028 reset=1 at a rising edge: posicao=0, prescaler=0, passo edge register=0, avanco=0, ciclo_completo=0. Resulting codes: codigo3=110, codigo2=111, codigo1=000, codigo0=001.
REQ-029 reset dominates enable, passo, and a terminal count in the same cycle; no advance or pulse is produced.
REQ-030 A passo held high across reset deassertion shall not produce a step; the edge register samples passo from the first post-reset cycle.

Verification (DIV_MAX=3)
REQ-031 Reset, then enable=1, direcao=0 for 16 cycles -> posicao advances every 4 cycles: 0,1,2,3; avanco pulses 4 times; after p=1, codes are 111,000,001,010.
REQ-032 enable=1, direcao=0 from p=7 at terminal count -> posicao=0, ciclo_completo=1 for 1 cycle, codes 110,111,000,001.
REQ-033 From reset, direcao=1, enable=1 -> first advance gives posicao=7, ciclo_completo=1, codes 101,110,111,000.
REQ-034 enable=0, passo high for 5 cycles then low, twice -> posicao moves by exactly 2; prescaler value unchanged throughout.
REQ-035 enable=1 with passo toggling every cycle -> advances only at terminal counts; no extra avanco pulses.
REQ-036 Reset asserted for 1 cycle at p=5 mid-count, with passo=1 held -> posicao=0, no pulses, no step after reset until passo falls and rises again.
